// File: rtl/rf_pkg.sv
// Shared definitions for the multiport register file.
//   DEF_WIDTH / DEF_DEPTH : default data width and register count
//   busy_vec_t            : pending-producer vector for the default depth
//   addr_writable()       : true unless the address is the hardwired zero register
package rf_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_DEPTH = 32;

  typedef logic [DEF_DEPTH-1:0] busy_vec_t;

  function automatic logic addr_writable(input int unsigned addr, input logic zero_reg);
    return !(zero_reg && (addr == 0));
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-producer scoreboard: one busy bit per register.
//   clk, rst_n        : clock, asynchronous active-low reset
//   rsv_en, rsv_add   : reserve request, sets busy at the next edge
//   wa_vld/wa_add,
//   wb_vld/wb_add     : qualified writes, clear busy at the commit edge
//   ra, rb            : lookup addresses
//   busy_a, busy_b    : busy status of ra / rb, masked by a same-cycle write
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned AW       = $clog2(DEPTH),
  parameter int unsigned ZERO_REG = 1,
  parameter type         busy_t   = busy_vec_t
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rsv_en,
  input  logic [AW-1:0] rsv_add,
  input  logic          wa_vld,
  input  logic [AW-1:0] wa_add,
  input  logic          wb_vld,
  input  logic [AW-1:0] wb_add,
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] rb,
  output logic          busy_a,
  output logic          busy_b
);

  busy_t busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (wa_vld) busy_d[wa_add] = 1'b0;
    if (wb_vld) busy_d[wb_add] = 1'b0;
    // Reserve is applied last so it wins over a same-cycle write.
    if (rsv_en && addr_writable(32'(rsv_add), ZERO_REG != 0)) busy_d[rsv_add] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  always_comb begin
    busy_a = busy_q[ra] && !((wa_vld && (wa_add == ra)) || (wb_vld && (wb_add == ra)));
    busy_b = busy_q[rb] && !((wa_vld && (wa_add == rb)) || (wb_vld && (wb_add == rb)));
  end

endmodule

// File: rtl/rf_multiport.sv
// Two-read / two-write register file with write-through bypass, optional
// hardwired zero register, pending-producer scoreboard and sticky
// write-collision flag.
//   CLK, RST_n                 : clock, asynchronous active-low reset
//   Ra, Rb, RD_en, Qa, Qb      : combinational read ports (0 when RD_en=0)
//   WA_*, WB_*                 : write ports, port B wins on same address
//   RSV_en, RSV_add            : reserve (mark register busy)
//   busy_a, busy_b             : busy status of Ra / Rb
//   wr_conflict                : sticky same-address dual-write flag
module rf_multiport
  import rf_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned AW       = $clog2(DEPTH),
  parameter int unsigned ZERO_REG = 1
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic [AW-1:0]    Ra,
  input  logic [AW-1:0]    Rb,
  input  logic             RD_en,
  output logic [WIDTH-1:0] Qa,
  output logic [WIDTH-1:0] Qb,
  input  logic             WA_en,
  input  logic             WB_en,
  input  logic [AW-1:0]    WA_add,
  input  logic [AW-1:0]    WB_add,
  input  logic [WIDTH-1:0] WA_D,
  input  logic [WIDTH-1:0] WB_D,
  input  logic             RSV_en,
  input  logic [AW-1:0]    RSV_add,
  output logic             busy_a,
  output logic             busy_b,
  output logic             wr_conflict
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             wr_conflict_q, wr_conflict_d;
  logic             wa_vld, wb_vld;

  // Writes are qualified by reset so that bypass data cannot leak out while
  // RST_n is low, and by writability so r0 never sees a write or a bypass.
  assign wa_vld = WA_en && RST_n && addr_writable(32'(WA_add), ZERO_REG != 0);
  assign wb_vld = WB_en && RST_n && addr_writable(32'(WB_add), ZERO_REG != 0);

  always_comb begin
    mem_d = mem_q;
    if (wa_vld) mem_d[WA_add] = WA_D;
    if (wb_vld) mem_d[WB_add] = WB_D;
    wr_conflict_d = wr_conflict_q || (wa_vld && wb_vld && (WA_add == WB_add));
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      mem_q         <= '{default: '0};
      wr_conflict_q <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  // r0 under ZERO_REG is never written and never bypassed, so the stored
  // value (reset to 0) is what it reads back.
  always_comb begin
    Qa = '0;
    Qb = '0;
    if (RD_en) begin
      if (wb_vld && (WB_add == Ra))      Qa = WB_D;
      else if (wa_vld && (WA_add == Ra)) Qa = WA_D;
      else                               Qa = mem_q[Ra];
      if (wb_vld && (WB_add == Rb))      Qb = WB_D;
      else if (wa_vld && (WA_add == Rb)) Qb = WA_D;
      else                               Qb = mem_q[Rb];
    end
  end

  assign wr_conflict = wr_conflict_q;

  rf_scoreboard #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .ZERO_REG (ZERO_REG),
    .busy_t   (logic [DEPTH-1:0])
  ) u_scoreboard (
    .clk     (CLK),
    .rst_n   (RST_n),
    .rsv_en  (RSV_en),
    .rsv_add (RSV_add),
    .wa_vld  (wa_vld),
    .wa_add  (WA_add),
    .wb_vld  (wb_vld),
    .wb_add  (WB_add),
    .ra      (Ra),
    .rb      (Rb),
    .busy_a  (busy_a),
    .busy_b  (busy_b)
  );

endmodule

// File: tb/tb_rf_multiport.sv
module tb_rf_multiport;
  import rf_pkg::*;

  localparam int W = DEF_WIDTH;
  localparam int D = DEF_DEPTH;
  localparam int A = $clog2(D);

  logic         CLK = 1'b0;
  logic         RST_n = 1'b1;
  logic [A-1:0] Ra, Rb, WA_add, WB_add, RSV_add;
  logic         RD_en, WA_en, WB_en, RSV_en;
  logic [W-1:0] WA_D, WB_D, Qa, Qb;
  logic         busy_a, busy_b, wr_conflict;

  always #5 CLK = ~CLK;

  rf_multiport #(.WIDTH(W), .DEPTH(D), .AW(A), .ZERO_REG(1)) dut (
    .CLK(CLK), .RST_n(RST_n), .Ra(Ra), .Rb(Rb), .RD_en(RD_en), .Qa(Qa), .Qb(Qb),
    .WA_en(WA_en), .WB_en(WB_en), .WA_add(WA_add), .WB_add(WB_add),
    .WA_D(WA_D), .WB_D(WB_D), .RSV_en(RSV_en), .RSV_add(RSV_add),
    .busy_a(busy_a), .busy_b(busy_b), .wr_conflict(wr_conflict)
  );

  typedef enum int {S_QA, S_QB, S_BA, S_BB, S_CF} sel_e;
  typedef struct {
    string        name;
    sel_e         sel;
    logic [W-1:0] val;
  } exp_t;

  exp_t         expq[$];
  logic [W-1:0] obsq[$];
  int unsigned  n_checks = 0;
  int unsigned  n_pass = 0;

  // Reference state
  logic [W-1:0] ref_mem [D];
  logic [D-1:0] ref_busy;
  logic         ref_conf;

  task automatic model_clear();
    for (int i = 0; i < D; i++) ref_mem[i] = '0;
    ref_busy = '0;
    ref_conf = 1'b0;
  endtask

  function automatic logic [W-1:0] exp_q(input logic [A-1:0] addr);
    if (!RD_en || !RST_n || addr == 0) return '0;
    if (WB_en && WB_add == addr) return WB_D;
    if (WA_en && WA_add == addr) return WA_D;
    return ref_mem[addr];
  endfunction

  function automatic logic exp_busy(input logic [A-1:0] addr);
    if (!RST_n || addr == 0) return 1'b0;
    if ((WA_en && WA_add == addr) || (WB_en && WB_add == addr)) return 1'b0;
    return ref_busy[addr];
  endfunction

  // Advance the reference with the currently driven inputs, then cross the edge.
  task automatic tick();
    if (RST_n) begin
      if (WA_en && WA_add != 0) begin ref_mem[WA_add] = WA_D; ref_busy[WA_add] = 1'b0; end
      if (WB_en && WB_add != 0) begin ref_mem[WB_add] = WB_D; ref_busy[WB_add] = 1'b0; end
      if (RSV_en && RSV_add != 0) ref_busy[RSV_add] = 1'b1;
      if (WA_en && WB_en && WA_add == WB_add && WA_add != 0) ref_conf = 1'b1;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    Ra = '0; Rb = '0; RD_en = 1'b0;
    WA_en = 1'b0; WB_en = 1'b0; WA_add = '0; WB_add = '0; WA_D = '0; WB_D = '0;
    RSV_en = 1'b0; RSV_add = '0;
  endtask

  function automatic logic [W-1:0] observe(input sel_e s);
    case (s)
      S_QA:    return Qa;
      S_QB:    return Qb;
      S_BA:    return W'(busy_a);
      S_BB:    return W'(busy_b);
      default: return W'(wr_conflict);
    endcase
  endfunction

  task automatic want(input string name, input sel_e s, input logic [W-1:0] v);
    expq.push_back('{name: name, sel: s, val: v});
  endtask

  // Capture DUT output for every expectation not yet sampled.
  task automatic sample();
    while (obsq.size() < expq.size()) obsq.push_back(observe(expq[obsq.size()].sel));
  endtask

  task automatic test_reset();
    exp_t e; logic [W-1:0] o;
    model_clear();
    idle();
    #2 RST_n = 1'b0;
    RD_en = 1'b1; Ra = 5; Rb = 5;
    WA_en = 1'b1; WA_add = 5; WA_D = 32'hAAAA_5555; RSV_en = 1'b1; RSV_add = 5;
    want("rst_qa", S_QA, '0); want("rst_qb", S_QB, '0);
    want("rst_busy_a", S_BA, '0); want("rst_conf", S_CF, '0);
    #1 sample();
    tick();
    idle(); RST_n = 1'b1; RD_en = 1'b1; Ra = 5;
    want("rst_write_lost", S_QA, '0); want("rst_rsv_lost", S_BA, '0);
    #1 sample();
    while (expq.size() != 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); n_checks++;
      if (o !== e.val) $display("FAIL %s: got %h want %h", e.name, o, e.val); else n_pass++;
    end
  endtask

  task automatic test_basic_write();
    exp_t e; logic [W-1:0] o;
    @(negedge CLK);
    idle(); WA_en = 1'b1; WA_add = 5; WA_D = 32'hDEAD_BEEF;
    tick();
    for (int i = 0; i < D; i++) begin
      @(negedge CLK);
      idle(); RD_en = 1'b1; Ra = A'(i); Rb = A'(D - 1 - i);
      want($sformatf("rd_a_r%0d", i), S_QA, (i == 5) ? 32'hDEAD_BEEF : 32'h0);
      want($sformatf("rd_b_r%0d", D - 1 - i), S_QB, ((D - 1 - i) == 5) ? 32'hDEAD_BEEF : 32'h0);
      #1 sample();
    end
    while (expq.size() != 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); n_checks++;
      if (o !== e.val) $display("FAIL %s: got %h want %h", e.name, o, e.val); else n_pass++;
    end
  endtask

  task automatic test_bypass();
    exp_t e; logic [W-1:0] o;
    @(negedge CLK);
    idle(); RD_en = 1'b1; Ra = 7; Rb = 7;
    WA_en = 1'b1; WA_add = 7; WA_D = 32'h1234;
    want("byp_qa", S_QA, 32'h1234); want("byp_qb", S_QB, 32'h1234);
    #1 sample();
    RD_en = 1'b0;
    want("byp_rd_off_qa", S_QA, '0); want("byp_rd_off_qb", S_QB, '0);
    #1 sample();
    tick();
    idle(); RD_en = 1'b1; Ra = 7;
    want("byp_stored", S_QA, 32'h1234);
    #1 sample();
    while (expq.size() != 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); n_checks++;
      if (o !== e.val) $display("FAIL %s: got %h want %h", e.name, o, e.val); else n_pass++;
    end
  endtask

  task automatic test_collision();
    exp_t e; logic [W-1:0] o;
    @(negedge CLK);
    idle(); RD_en = 1'b1; Ra = 3; Rb = 3;
    WA_en = 1'b1; WA_add = 3; WA_D = 32'h11;
    WB_en = 1'b1; WB_add = 3; WB_D = 32'h22;
    want("col_byp_qa", S_QA, 32'h22); want("col_byp_qb", S_QB, 32'h22);
    want("col_conf_before", S_CF, '0);
    #1 sample();
    tick();
    idle(); RD_en = 1'b1; Ra = 3;
    want("col_stored", S_QA, 32'h22); want("col_conf_set", S_CF, 1);
    #1 sample();
    WA_en = 1'b1; WA_add = 4; WA_D = 32'h44;
    tick(); tick();
    idle();
    want("col_conf_held", S_CF, 1);
    #1 sample();
    while (expq.size() != 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); n_checks++;
      if (o !== e.val) $display("FAIL %s: got %h want %h", e.name, o, e.val); else n_pass++;
    end
  endtask

  task automatic test_zero_reg();
    exp_t e; logic [W-1:0] o;
    @(negedge CLK);
    idle(); RD_en = 1'b1; Ra = 0; Rb = 0;
    WA_en = 1'b1; WA_add = 0; WA_D = 32'hFFFF;
    WB_en = 1'b1; WB_add = 0; WB_D = 32'hFFFF;
    RSV_en = 1'b1; RSV_add = 0;
    want("zr_byp_qa", S_QA, '0); want("zr_byp_qb", S_QB, '0);
    #1 sample();
    tick();
    idle(); RD_en = 1'b1; Ra = 0;
    want("zr_qa", S_QA, '0); want("zr_busy_a", S_BA, '0);
    #1 sample();
    while (expq.size() != 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); n_checks++;
      if (o !== e.val) $display("FAIL %s: got %h want %h", e.name, o, e.val); else n_pass++;
    end
  endtask

  task automatic test_scoreboard();
    exp_t e; logic [W-1:0] o;
    @(negedge CLK);
    idle(); RSV_en = 1'b1; RSV_add = 9; Ra = 9;
    want("sb_not_yet", S_BA, '0);
    #1 sample();
    tick();
    idle(); Ra = 9; Rb = 9;
    want("sb_busy_a_rd_off", S_BA, 1); want("sb_busy_b_rd_off", S_BB, 1);
    #1 sample();
    WB_en = 1'b1; WB_add = 9; WB_D = 32'h99;
    want("sb_wr_mask_a", S_BA, '0); want("sb_wr_mask_b", S_BB, '0);
    #1 sample();
    tick();
    idle(); Ra = 9;
    want("sb_cleared", S_BA, '0);
    #1 sample();
    RSV_en = 1'b1; RSV_add = 9; WA_en = 1'b1; WA_add = 9; WA_D = 32'h77;
    tick();
    idle(); RSV_en = 1'b1; RSV_add = 5;
    tick();
    idle(); RD_en = 1'b1; Ra = 9; Rb = 5;
    want("sb_rsv_wins", S_BA, 1); want("sb_rsv_wr_data", S_QA, 32'h77);
    want("sb_r5_busy", S_BB, 1);
    #1 sample();
    while (expq.size() != 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); n_checks++;
      if (o !== e.val) $display("FAIL %s: got %h want %h", e.name, o, e.val); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    exp_t e; logic [W-1:0] o;
    @(negedge CLK);
    idle(); RD_en = 1'b1; Ra = 9; Rb = 5;
    want("mid_pre_qa", S_QA, 32'h77); want("mid_pre_qb", S_QB, 32'hDEAD_BEEF);
    want("mid_pre_busy_a", S_BA, 1); want("mid_pre_busy_b", S_BB, 1);
    want("mid_pre_conf", S_CF, 1);
    #1 sample();
    #1 RST_n = 1'b0;
    model_clear();
    want("mid_qa", S_QA, '0); want("mid_qb", S_QB, '0);
    want("mid_busy_a", S_BA, '0); want("mid_busy_b", S_BB, '0);
    want("mid_conf", S_CF, '0);
    #1 sample();
    WB_en = 1'b1; WB_add = 5; WB_D = 32'h55;
    tick();
    idle(); RST_n = 1'b1; RD_en = 1'b1; Ra = 5;
    want("mid_write_lost", S_QA, '0);
    #1 sample();
    WB_en = 1'b1; WB_add = 5; WB_D = 32'h55;
    tick();
    idle(); RD_en = 1'b1; Ra = 5;
    want("mid_resume", S_QA, 32'h55);
    #1 sample();
    while (expq.size() != 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); n_checks++;
      if (o !== e.val) $display("FAIL %s: got %h want %h", e.name, o, e.val); else n_pass++;
    end
  endtask

  task automatic test_random();
    exp_t e; logic [W-1:0] o;
    for (int c = 0; c < 60; c++) begin
      @(negedge CLK);
      RD_en   = 1'($urandom_range(0, 3) != 0);
      Ra      = A'($urandom_range(0, 11));
      Rb      = A'($urandom_range(0, 11));
      WA_en   = 1'($urandom_range(0, 1));
      WB_en   = 1'($urandom_range(0, 1));
      WA_add  = A'($urandom_range(0, 11));
      WB_add  = A'($urandom_range(0, 11));
      WA_D    = W'($urandom);
      WB_D    = W'($urandom);
      RSV_en  = 1'($urandom_range(0, 1));
      RSV_add = A'($urandom_range(0, 11));
      want($sformatf("rnd%0d_qa", c), S_QA, exp_q(Ra));
      want($sformatf("rnd%0d_qb", c), S_QB, exp_q(Rb));
      want($sformatf("rnd%0d_busy_a", c), S_BA, W'(exp_busy(Ra)));
      want($sformatf("rnd%0d_busy_b", c), S_BB, W'(exp_busy(Rb)));
      want($sformatf("rnd%0d_conf", c), S_CF, W'(ref_conf));
      #1 sample();
      tick();
    end
    idle();
    while (expq.size() != 0) begin
      e = expq.pop_front(); o = obsq.pop_front(); n_checks++;
      if (o !== e.val) $display("FAIL %s: got %h want %h", e.name, o, e.val); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_bypass();
    test_collision();
    test_zero_reg();
    test_scoreboard();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
